// File: rtl/uart_prg_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_prg_loader
// Purpose  : 8N1 UART receiver that packs bytes little-endian into 32-bit
//            words and writes them to a data memory programming port.
// Revision : 1.0 - initial release
// ============================================================================
module uart_prg_loader #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        prg_mode,
    input  logic        rxd,
    output logic        prg_we,
    output logic [31:0] prg_addr,
    output logic [31:0] prg_wd,
    output logic        busy,
    output logic        frame_err,
    output logic [11:0] word_cnt
);

    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic        rxd_meta_q, rxd_sync_q;
    logic [1:0]  flush_q;
    logic        armed_q;
    state_t      state_q,    state_d;
    logic [15:0] clk_cnt_q,  clk_cnt_d;
    logic [2:0]  bit_cnt_q,  bit_cnt_d;
    logic [7:0]  shift_q,    shift_d;
    logic [23:0] word_q,     word_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        prg_we_q,   prg_we_d;
    logic [31:0] prg_wd_q,   prg_wd_d;
    logic [10:0] addr_idx_q, addr_idx_d;
    logic [11:0] word_cnt_q, word_cnt_d;
    logic        frame_err_q, frame_err_d;
    logic        byte_ok;

    // A start is accepted only after the line has been seen idle-high once the
    // synchroniser has flushed, so a low line at reset release or mode entry
    // never begins a frame mid-byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            flush_q    <= 2'b00;
            armed_q    <= 1'b0;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            flush_q    <= {flush_q[0], 1'b1};
            if (!prg_mode) begin
                armed_q <= 1'b0;
            end else if (flush_q[1] && rxd_sync_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clk_cnt_q   <= 16'd0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            word_q      <= 24'd0;
            byte_cnt_q  <= 2'd0;
            prg_we_q    <= 1'b0;
            prg_wd_q    <= 32'd0;
            addr_idx_q  <= 11'd0;
            word_cnt_q  <= 12'd0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            word_q      <= word_d;
            byte_cnt_q  <= byte_cnt_d;
            prg_we_q    <= prg_we_d;
            prg_wd_q    <= prg_wd_d;
            addr_idx_q  <= addr_idx_d;
            word_cnt_q  <= word_cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + 16'd1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        word_d      = word_q;
        byte_cnt_d  = byte_cnt_q;
        prg_we_d    = 1'b0;
        prg_wd_d    = prg_wd_q;
        addr_idx_d  = addr_idx_q;
        word_cnt_d  = word_cnt_q;
        frame_err_d = frame_err_q;
        byte_ok     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                clk_cnt_d = 16'd0;
                if (armed_q && !rxd_sync_q) begin
                    state_d   = S_START;
                    bit_cnt_d = 3'd0;
                end
            end
            S_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = 16'd0;
                    state_d   = rxd_sync_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = 16'd0;
                    shift_d   = {rxd_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = 16'd0;
                    state_d   = S_IDLE;
                    if (rxd_sync_q) begin
                        byte_ok = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Address, count and byte slot advance the cycle after the strobe.
        if (prg_we_q) begin
            addr_idx_d = addr_idx_q + 11'd1;
            byte_cnt_d = 2'd0;
            if (word_cnt_q != 12'hFFF) begin
                word_cnt_d = word_cnt_q + 12'd1;
            end
        end

        if (byte_ok) begin
            unique case (byte_cnt_q)
                2'd0: word_d[7:0]   = shift_q;
                2'd1: word_d[15:8]  = shift_q;
                2'd2: word_d[23:16] = shift_q;
                default: begin
                    prg_we_d = 1'b1;
                    prg_wd_d = {shift_q, word_q};
                end
            endcase
            if (byte_cnt_q != 2'd3) begin
                byte_cnt_d = byte_cnt_q + 2'd1;
            end
        end

        if (!prg_mode) begin
            state_d     = S_IDLE;
            clk_cnt_d   = 16'd0;
            byte_cnt_d  = 2'd0;
            addr_idx_d  = 11'd0;
            word_cnt_d  = 12'd0;
            prg_we_d    = 1'b0;
            prg_wd_d    = prg_wd_q;
            frame_err_d = 1'b0;
        end
    end

    assign prg_we    = prg_we_q;
    assign prg_addr  = {19'd0, addr_idx_q, 2'b00};
    assign prg_wd    = prg_wd_q;
    assign frame_err = frame_err_q;
    assign word_cnt  = word_cnt_q;
    assign busy      = (state_q != S_IDLE) || (byte_cnt_q != 2'd0) || prg_we_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_prg_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_prg_loader
// Purpose  : Directed self-checking bench for uart_prg_loader (8 clks/bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_prg_loader;

    localparam int CPB = 8;
    localparam int GAP = 16;

    logic        clk;
    logic        reset;
    logic        prg_mode;
    logic        rxd;
    logic        prg_we;
    logic [31:0] prg_addr;
    logic [31:0] prg_wd;
    logic        busy;
    logic        frame_err;
    logic [11:0] word_cnt;

    int n_cmp = 0;
    int n_err = 0;

    int          we_total   = 0;
    int          we_run     = 0;
    int          we_run_max = 0;
    logic [31:0] mon_addr   = 32'hFFFF_FFFF;
    logic [31:0] mon_wd     = 32'hFFFF_FFFF;

    uart_prg_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .prg_mode  (prg_mode),
        .rxd       (rxd),
        .prg_we    (prg_we),
        .prg_addr  (prg_addr),
        .prg_wd    (prg_wd),
        .busy      (busy),
        .frame_err (frame_err),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe observer: records every write and the longest strobe run.
    always @(negedge clk) begin
        if (prg_we) begin
            we_total = we_total + 1;
            mon_addr = prg_addr;
            mon_wd   = prg_wd;
            we_run   = we_run + 1;
            if (we_run > we_run_max) we_run_max = we_run;
        end else begin
            we_run = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], 1'b1);
        end
    endtask

    task automatic clear_mode();
        prg_mode = 1'b0;
        repeat (2) @(negedge clk);
        prg_mode = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; prg_mode = 1'b1; rxd = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (prg_we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", prg_we); end
        n_cmp++; if (prg_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", prg_addr); end
        n_cmp++; if (prg_wd !== 32'h0) begin n_err++; $display("FAIL rst_wd: got %h want 0", prg_wd); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rst_ferr: got %b want 0", frame_err); end
        n_cmp++; if (word_cnt !== 12'd0) begin n_err++; $display("FAIL rst_wcnt: got %0d want 0", word_cnt); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_word();
        int base;
        base = we_total;
        send_word(32'h1234_5678);
        n_cmp++; if (we_total - base !== 1) begin n_err++; $display("FAIL w0_count: got %0d want 1", we_total - base); end
        n_cmp++; if (mon_addr !== 32'h0) begin n_err++; $display("FAIL w0_addr: got %h want 0", mon_addr); end
        n_cmp++; if (mon_wd !== 32'h1234_5678) begin n_err++; $display("FAIL w0_wd: got %h want 12345678", mon_wd); end
        n_cmp++; if (prg_addr !== 32'h4) begin n_err++; $display("FAIL w0_next_addr: got %h want 4", prg_addr); end
        n_cmp++; if (word_cnt !== 12'd1) begin n_err++; $display("FAIL w0_wcnt: got %0d want 1", word_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL w0_busy: got %b want 0", busy); end
        n_cmp++; if (prg_wd !== 32'h1234_5678) begin n_err++; $display("FAIL w0_wd_hold: got %h want 12345678", prg_wd); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = we_total;
        send_word(32'hDEAD_BEEF);
        send_word(32'h0F1E_2D3C);
        n_cmp++; if (we_total - base !== 2) begin n_err++; $display("FAIL b2b_count: got %0d want 2", we_total - base); end
        n_cmp++; if (mon_addr !== 32'h8) begin n_err++; $display("FAIL b2b_addr: got %h want 8", mon_addr); end
        n_cmp++; if (mon_wd !== 32'h0F1E_2D3C) begin n_err++; $display("FAIL b2b_wd: got %h want 0f1e2d3c", mon_wd); end
        n_cmp++; if (prg_addr !== 32'hC) begin n_err++; $display("FAIL b2b_next_addr: got %h want c", prg_addr); end
        n_cmp++; if (word_cnt !== 12'd3) begin n_err++; $display("FAIL b2b_wcnt: got %0d want 3", word_cnt); end
        n_cmp++; if (we_run_max !== 1) begin n_err++; $display("FAIL strobe_width: got %0d want 1", we_run_max); end
    endtask

    task automatic test_frame_err();
        int base;
        clear_mode();
        n_cmp++; if (prg_addr !== 32'h0) begin n_err++; $display("FAIL mode_clr_addr: got %h want 0", prg_addr); end
        n_cmp++; if (word_cnt !== 12'd0) begin n_err++; $display("FAIL mode_clr_wcnt: got %0d want 0", word_cnt); end
        base = we_total;
        send_byte(8'hAA, 1'b0);
        n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_set: got %b want 1", frame_err); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ferr_busy: got %b want 0", busy); end
        send_word(32'h4433_2211);
        n_cmp++; if (we_total - base !== 1) begin n_err++; $display("FAIL ferr_count: got %0d want 1", we_total - base); end
        n_cmp++; if (mon_addr !== 32'h0) begin n_err++; $display("FAIL ferr_addr: got %h want 0", mon_addr); end
        n_cmp++; if (mon_wd !== 32'h4433_2211) begin n_err++; $display("FAIL ferr_wd: got %h want 44332211", mon_wd); end
        n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_sticky: got %b want 1", frame_err); end
    endtask

    task automatic test_glitch();
        int base;
        logic saw_busy;
        base = we_total;
        saw_busy = 1'b0;
        rxd = 1'b0;
        repeat (2) @(negedge clk);
        rxd = 1'b1;
        for (int i = 2; i < CPB / 2 + 3; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        n_cmp++; if (saw_busy !== 1'b1) begin n_err++; $display("FAIL glitch_seen: got %b want 1", saw_busy); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy: got %b want 0", busy); end
        repeat (GAP) @(negedge clk);
        n_cmp++; if (we_total - base !== 0) begin n_err++; $display("FAIL glitch_we: got %0d want 0", we_total - base); end
        n_cmp++; if (prg_addr !== 32'h4) begin n_err++; $display("FAIL glitch_addr: got %h want 4", prg_addr); end
        n_cmp++; if (word_cnt !== 12'd1) begin n_err++; $display("FAIL glitch_wcnt: got %0d want 1", word_cnt); end
    endtask

    task automatic test_mode_abort();
        int base;
        base = we_total;
        prg_mode = 1'b0;
        send_word(32'h5566_7788);
        n_cmp++; if (we_total - base !== 0) begin n_err++; $display("FAIL off_we: got %0d want 0", we_total - base); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL off_busy: got %b want 0", busy); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL off_ferr: got %b want 0", frame_err); end
        prg_mode = 1'b1;
        repeat (4) @(negedge clk);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL partial_busy: got %b want 1", busy); end
        prg_mode = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        prg_mode = 1'b1;
        repeat (4) @(negedge clk);
        send_word(32'hC4C3_C2C1);
        n_cmp++; if (we_total - base !== 1) begin n_err++; $display("FAIL abort_count: got %0d want 1", we_total - base); end
        n_cmp++; if (mon_addr !== 32'h0) begin n_err++; $display("FAIL abort_addr: got %h want 0", mon_addr); end
        n_cmp++; if (mon_wd !== 32'hC4C3_C2C1) begin n_err++; $display("FAIL abort_wd: got %h want c4c3c2c1", mon_wd); end
    endtask

    task automatic test_wrap();
        clear_mode();
        force dut.addr_idx_q = 11'h7FE;
        force dut.word_cnt_q = 12'd2046;
        repeat (2) @(negedge clk);
        release dut.addr_idx_q;
        release dut.word_cnt_q;
        @(negedge clk);
        send_word(32'h0102_0304);
        n_cmp++; if (mon_addr !== 32'h1FF8) begin n_err++; $display("FAIL wrap_a1: got %h want 1ff8", mon_addr); end
        n_cmp++; if (mon_wd !== 32'h0102_0304) begin n_err++; $display("FAIL wrap_wd1: got %h want 01020304", mon_wd); end
        send_word(32'h0506_0708);
        n_cmp++; if (mon_addr !== 32'h1FFC) begin n_err++; $display("FAIL wrap_a2: got %h want 1ffc", mon_addr); end
        n_cmp++; if (prg_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next: got %h want 0", prg_addr); end
        n_cmp++; if (word_cnt !== 12'd2048) begin n_err++; $display("FAIL wrap_wcnt: got %0d want 2048", word_cnt); end
    endtask

    task automatic test_saturate();
        force dut.word_cnt_q = 12'd4094;
        repeat (2) @(negedge clk);
        release dut.word_cnt_q;
        @(negedge clk);
        send_word(32'hAABB_CCDD);
        n_cmp++; if (word_cnt !== 12'd4095) begin n_err++; $display("FAIL sat_1: got %0d want 4095", word_cnt); end
        send_word(32'h1122_3344);
        n_cmp++; if (word_cnt !== 12'd4095) begin n_err++; $display("FAIL sat_2: got %0d want 4095", word_cnt); end
        n_cmp++; if (prg_addr !== 32'h8) begin n_err++; $display("FAIL sat_addr: got %h want 8", prg_addr); end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        clear_mode();
        send_word(32'h4030_2010);
        send_byte(8'h50, 1'b1);
        send_byte(8'h60, 1'b1);
        rxd = 1'b0;
        repeat (4 * CPB) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (prg_addr !== 32'h0) begin n_err++; $display("FAIL mrst_addr: got %h want 0", prg_addr); end
        n_cmp++; if (prg_wd !== 32'h0) begin n_err++; $display("FAIL mrst_wd: got %h want 0", prg_wd); end
        n_cmp++; if (word_cnt !== 12'd0) begin n_err++; $display("FAIL mrst_wcnt: got %0d want 0", word_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mrst_busy: got %b want 0", busy); end
        base = we_total;
        repeat (3 * CPB) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mrst_low_line: got %b want 0", busy); end
        rxd = 1'b1;
        repeat (GAP) @(negedge clk);
        send_word(32'hF0DE_BC9A);
        n_cmp++; if (we_total - base !== 1) begin n_err++; $display("FAIL mrst_count: got %0d want 1", we_total - base); end
        n_cmp++; if (mon_addr !== 32'h0) begin n_err++; $display("FAIL mrst_waddr: got %h want 0", mon_addr); end
        n_cmp++; if (mon_wd !== 32'hF0DE_BC9A) begin n_err++; $display("FAIL mrst_wwd: got %h want f0debc9a", mon_wd); end
        n_cmp++; if (word_cnt !== 12'd1) begin n_err++; $display("FAIL mrst_wcnt2: got %0d want 1", word_cnt); end
    endtask

    initial begin
        reset = 1'b1; prg_mode = 1'b0; rxd = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_mode_abort();
        test_wrap();
        test_saturate();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_prg_loader.md
UART_PRG_LOADER -- requirements
Module: uart_prg_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous reset, active-high.
REQ-004 SHALL have port prg_mode  input  1  1: loading enabled; 0: run mode, loader idle.
REQ-005 SHALL have port rxd  input  1  asynchronous UART serial input, idle high, 8N1.
REQ-006 SHALL have port prg_we  output  1  one-cycle write strobe to data memory programmer port.
REQ-007 SHALL have port prg_addr  output  32  byte address of the current word; bits [1:0] and [31:13] always 0.
REQ-008 SHALL have port prg_wd  output  32  assembled write data.
REQ-009 SHALL have port busy  output  1  high while a UART frame is in progress or a partial word is held.
REQ-010 SHALL have port frame_err  output  1  sticky: a stop bit was sampled low.
REQ-011 SHALL have port word_cnt  output  12  words written since the last clear, saturating at 4095.

Function
REQ-012 SHALL pass rxd through a 2-flop synchroniser, reset value 1; all receiver decisions use the synchronised signal.
REQ-013 SHALL implement receiver FSM states IDLE, START, DATA, STOP.
REQ-014 IDLE -> START on synchronised rxd = 0; the bit counter is cleared.
REQ-015 START: at CLKS_PER_BIT/2 (integer division) cycles, if rxd = 0 -> DATA; otherwise treat as a glitch -> IDLE with no byte delivered.
REQ-016 DATA: SHALL sample every CLKS_PER_BIT cycles, 8 samples, LSB first, then -> STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles, sample the stop bit. 1 = byte valid. 0 = set frame_err and discard the byte. Either way -> IDLE.
REQ-018 SHALL pack valid bytes little-endian: byte k (k = 0..3) goes to word bits [8k+7:8k]; a 2-bit byte counter tracks k.
REQ-019 On the 4th valid byte, the next cycle SHALL present prg_wd = assembled word and pulse prg_we high for exactly one cycle, with prg_addr holding the current address.
REQ-020 The cycle after the prg_we pulse, prg_addr SHALL advance by 4 modulo 0x2000 (0x1FFC wraps to 0x0000), word_cnt SHALL increment (saturate at 4095), and the byte counter SHALL return to 0.
REQ-021 prg_wd SHALL hold its last value between strobes.
REQ-022 While prg_mode = 0: FSM held in IDLE; byte counter, prg_addr and word_cnt cleared to 0; prg_we = 0; frame_err cleared; frames arriving are ignored.
REQ-023 A prg_mode 1->0 transition mid-frame or mid-word SHALL abort it next cycle; no partial word is ever written.
REQ-024 busy = (FSM != IDLE) or (byte counter != 0) or prg_we.
REQ-025 Glitches and frame errors SHALL NOT change the byte counter, prg_addr or word_cnt.

Reset
REQ-026 reset SHALL take priority over all inputs, including prg_mode.
REQ-027 On reset: FSM = IDLE, synchroniser = 1, prg_we = 0, prg_addr = 0, prg_wd = 0, byte counter = 0, word_cnt = 0, frame_err = 0, busy = 0.
REQ-028 Reset asserted mid-frame SHALL discard the frame; reception restarts only on the next falling edge after reset deasserts.

Verification (CLKS_PER_BIT = 8)
REQ-029 prg_mode = 1; send bytes 0x78, 0x56, 0x34, 0x12 -> single prg_we pulse with prg_addr = 0x0, prg_wd = 0x12345678; then prg_addr = 0x4, word_cnt = 1.
REQ-030 Send 2048 words -> last write at prg_addr = 0x1FFC; prg_addr then wraps to 0x0; word_cnt = 2048.
REQ-031 Send 0xAA with stop bit forced 0, then 4 good bytes -> frame_err = 1; one write of the 4 good bytes at address 0x0.
REQ-032 Hold rxd low for 2 cycles only -> no byte, no state change, busy returns to 0 within CLKS_PER_BIT/2 + 3 cycles.
REQ-033 Send 2 bytes, drop prg_mode for 1 cycle, raise it, send 4 bytes -> exactly one write at 0x0 containing only the later 4 bytes.
REQ-034 Assert reset during DATA of byte 3 of the 2nd word -> all outputs at reset values; the next complete word is written to 0x0.
